rf_wr_arbiter: RTL and testbench

Shares the single register-file write port (we/wa/wd) between the one-tact core's writeback and two peripheral writers: UART receive and timer status. Core writeback is never delayed and passes straight through. Peripheral writes are accepted round-robin into a small FIFO and drained into idle write cycles. A queued peripheral write is cancelled if the core writes the same register first.

---
 rtl/rf_wr_arbiter_if.sv | 42 ++++
 rtl/rf_wr_arbiter.sv | 129 ++++++++++++
 tb/tb_rf_wr_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/rf_wr_arbiter_if.sv
// Register-file write-port bundle: core writeback, two peripheral writers
// (UART rx = p0, timer status = p1) and the shared register-file port.
//   master : drives core_* and pX_req/wa/wd, observes pX_ack and rf_*
//   slave  : the arbiter side
interface rf_wr_arbiter_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          core_we;
  logic [AW-1:0] core_wa;
  logic [DW-1:0] core_wd;

  logic          p0_req;
  logic [AW-1:0] p0_wa;
  logic [DW-1:0] p0_wd;
  logic          p0_ack;

  logic          p1_req;
  logic [AW-1:0] p1_wa;
  logic [DW-1:0] p1_wd;
  logic          p1_ack;

  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;

  modport master (
    output core_we, core_wa, core_wd,
    output p0_req, p0_wa, p0_wd,
    output p1_req, p1_wa, p1_wd,
    input  p0_ack, p1_ack,
    input  rf_we, rf_wa, rf_wd
  );

  modport slave (
    input  core_we, core_wa, core_wd,
    input  p0_req, p0_wa, p0_wd,
    input  p1_req, p1_wa, p1_wd,
    output p0_ack, p1_ack,
    output rf_we, rf_wa, rf_wd
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Shares the register-file write port between core writeback (pass-through,
// never delayed) and two peripheral writers queued round-robin into a FIFO
// that drains into idle write cycles. Queued entries whose address the core
// writes are marked dead and skipped.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   bus         : rf_wr_arbiter_if.slave (core_*, p0_*, p1_*, rf_*)
//   fifo_count  : entries held (live or dead)
//   fifo_full   : fifo_count == DEPTH
//   kill_cnt    : saturating count of entries cancelled by core writes
module rf_wr_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rf_wr_arbiter_if.slave           bus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic [7:0]               kill_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] live_q;
  logic [AW-1:0]    wa_q [DEPTH];
  logic [DW-1:0]    wd_q [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             rr;

  logic             can_acc;
  logic             gnt0;
  logic             gnt1;
  logic [AW-1:0]    sel_wa;
  logic [DW-1:0]    sel_wd;
  logic             push;
  logic             head_occ;
  logic             pop;
  logic [DEPTH-1:0] kill_vec;
  logic [CW-1:0]    kill_n;
  logic [8:0]       kill_sum;
  logic [7:0]       kill_next;
  logic [DEPTH-1:0] live_next;
  logic [CW-1:0]    count_next;
  logic             rr_next;

  // Accept: one grant per cycle, only with a free slot counted before any pop.
  always_comb begin
    can_acc = rst_n && (fifo_count < CW'(DEPTH));
    gnt0    = can_acc && bus.p0_req && (!bus.p1_req || !rr);
    gnt1    = can_acc && bus.p1_req && (!bus.p0_req || rr);
    sel_wa  = gnt1 ? bus.p1_wa : bus.p0_wa;
    sel_wd  = gnt1 ? bus.p1_wd : bus.p0_wd;
    // Writes to r0 are acked and dropped.
    push    = (gnt0 || gnt1) && (sel_wa != '0);
    rr_next = gnt0 ? 1'b1 : (gnt1 ? 1'b0 : rr);
  end

  assign bus.p0_ack = gnt0;
  assign bus.p1_ack = gnt1;

  // Write-port mux: core first, then a live head; dead heads pop silently.
  always_comb begin
    head_occ   = (fifo_count != '0);
    pop        = head_occ && (!live_q[rd_ptr] || !bus.core_we);
    bus.rf_we  = 1'b0;
    bus.rf_wa  = '0;
    bus.rf_wd  = '0;
    if (bus.core_we) begin
      bus.rf_we = 1'b1;
      bus.rf_wa = bus.core_wa;
      bus.rf_wd = bus.core_wd;
    end else if (head_occ && live_q[rd_ptr]) begin
      bus.rf_we = 1'b1;
      bus.rf_wa = wa_q[rd_ptr];
      bus.rf_wd = wd_q[rd_ptr];
    end
  end

  // Kill matching live entries; a same-cycle push lands live afterwards.
  always_comb begin
    kill_n = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      kill_vec[i] = bus.core_we && live_q[i] && (wa_q[i] == bus.core_wa);
      kill_n      = kill_n + CW'(kill_vec[i]);
    end
    kill_sum  = 9'(kill_cnt) + 9'(kill_n);
    kill_next = kill_sum[8] ? 8'hFF : kill_sum[7:0];

    live_next = live_q & ~kill_vec;
    if (pop)  live_next[rd_ptr] = 1'b0;
    if (push) live_next[wr_ptr] = 1'b1;

    count_next = CW'(fifo_count + CW'(push) - CW'(pop));
  end

  // Control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q     <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      rr         <= 1'b0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      kill_cnt   <= '0;
    end else begin
      live_q     <= live_next;
      rd_ptr     <= PW'(rd_ptr + PW'(pop));
      wr_ptr     <= PW'(wr_ptr + PW'(push));
      rr         <= rr_next;
      fifo_count <= count_next;
      fifo_full  <= (count_next == CW'(DEPTH));
      kill_cnt   <= kill_next;
    end
  end

  // Payload storage; validity is carried by live_q, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      wa_q[wr_ptr] <= sel_wa;
      wd_q[wr_ptr] <= sel_wd;
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: inputs change 1 time unit after posedge,
// outputs are sampled at negedge.
module tb_rf_wr_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic       clk;
  logic       rst_n;
  logic [2:0] fifo_count;
  logic       fifo_full;
  logic [7:0] kill_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic mon_en = 1'b0;
  logic saw11  = 1'b0;

  rf_wr_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  rf_wr_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .kill_cnt   (kill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags any register-file write carrying the killed UART payload.
  always @(negedge clk) begin
    if (mon_en && bus.rf_we && (bus.rf_wd == 32'h11)) saw11 = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    bus.core_we = we;
    bus.core_wa = wa;
    bus.core_wd = wd;
  endtask

  initial begin
    rst_n = 1'b0;
    core(1'b0, 5'd0, 32'h0);
    bus.p0_req = 1'b1; bus.p0_wa = 5'd3; bus.p0_wd = 32'h1;
    bus.p1_req = 1'b0; bus.p1_wa = 5'd0; bus.p1_wd = 32'h0;

    // Reset state; a pending request is not acked during reset.
    #3;
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_full",  32'(fifo_full),  32'd0);
    check("rst_kill",  32'(kill_cnt),   32'd0);
    check("rst_p0ack", 32'(bus.p0_ack), 32'd0);
    check("rst_rfwe",  32'(bus.rf_we),  32'd0);
    tick();
    bus.p0_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Core only: same-cycle pass-through.
    core(1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("core_we", 32'(bus.rf_we), 32'd1);
    check("core_wa", 32'(bus.rf_wa), 32'd5);
    check("core_wd", bus.rf_wd,      32'hDEADBEEF);
    tick();
    core(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("core_count", 32'(fifo_count), 32'd0);
    tick();

    // Round-robin fill while the core holds the port for 10 cycles.
    bus.p0_req = 1'b1; bus.p0_wa = 5'd10; bus.p0_wd = 32'hA0;
    bus.p1_req = 1'b1; bus.p1_wa = 5'd11; bus.p1_wd = 32'hB0;
    for (int i = 0; i < 10; i++) begin
      core(1'b1, 5'd20, 32'hC0DE);
      @(negedge clk);
      check($sformatf("rr_p0ack%0d", i), 32'(bus.p0_ack), 32'((i < 4) && (i % 2 == 0)));
      check($sformatf("rr_p1ack%0d", i), 32'(bus.p1_ack), 32'((i < 4) && (i % 2 == 1)));
      check($sformatf("rr_full%0d", i),  32'(fifo_full),  32'(i >= 4));
      check($sformatf("rr_rfwa%0d", i),  32'(bus.rf_wa),  32'd20);
      tick();
    end
    // Drain: first drain cycle still full, so no ack despite the pop.
    core(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("drain_noack0", 32'(bus.p0_ack), 32'd0);
        check("drain_noack1", 32'(bus.p1_ack), 32'd0);
      end
      check($sformatf("drain_we%0d", i), 32'(bus.rf_we), 32'd1);
      check($sformatf("drain_wa%0d", i), 32'(bus.rf_wa), (i % 2 == 0) ? 32'd10 : 32'd11);
      check($sformatf("drain_wd%0d", i), bus.rf_wd,      (i % 2 == 0) ? 32'hA0 : 32'hB0);
      tick();
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
    end
    @(negedge clk);
    check("drain_count", 32'(fifo_count), 32'd0);
    check("drain_idle",  32'(bus.rf_we),  32'd0);
    tick();

    // Single peripheral: ack in N, write in N+1.
    bus.p0_req = 1'b1; bus.p0_wa = 5'd2; bus.p0_wd = 32'h41;
    @(negedge clk);
    check("single_ack",  32'(bus.p0_ack), 32'd1);
    check("single_nowe", 32'(bus.rf_we),  32'd0);
    tick();
    bus.p0_req = 1'b0;
    @(negedge clk);
    check("single_we",    32'(bus.rf_we),    32'd1);
    check("single_wa",    32'(bus.rf_wa),    32'd2);
    check("single_wd",    bus.rf_wd,         32'h41);
    check("single_count", 32'(fifo_count),   32'd1);
    tick();
    @(negedge clk);
    check("single_count0", 32'(fifo_count), 32'd0);
    tick();

    // Kill: queue wa=7 and wa=8 behind a busy core, then core writes wa=7.
    mon_en = 1'b1;
    core(1'b1, 5'd20, 32'hC0DE);
    bus.p0_req = 1'b1; bus.p0_wa = 5'd7; bus.p0_wd = 32'h11;
    @(negedge clk);
    check("kill_p0ack", 32'(bus.p0_ack), 32'd1);
    tick();
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b1; bus.p1_wa = 5'd8; bus.p1_wd = 32'h22;
    @(negedge clk);
    check("kill_p1ack", 32'(bus.p1_ack), 32'd1);
    tick();
    bus.p1_req = 1'b0;
    core(1'b1, 5'd7, 32'h99);
    @(negedge clk);
    check("kill_corewa", 32'(bus.rf_wa),  32'd7);
    check("kill_corewd", bus.rf_wd,       32'h99);
    check("kill_count2", 32'(fifo_count), 32'd2);
    tick();
    core(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("kill_cnt",    32'(kill_cnt),   32'd1);
    check("kill_deadwe", 32'(bus.rf_we),  32'd0);
    tick();
    @(negedge clk);
    check("kill_count1", 32'(fifo_count), 32'd1);
    check("kill_we8",    32'(bus.rf_we),  32'd1);
    check("kill_wa8",    32'(bus.rf_wa),  32'd8);
    check("kill_wd8",    bus.rf_wd,       32'h22);
    tick();
    @(negedge clk);
    check("kill_count0", 32'(fifo_count), 32'd0);
    check("kill_no11",   32'(saw11),      32'd0);
    tick();
    mon_en = 1'b0;

    // Address 0: acked, not queued, no write.
    bus.p1_req = 1'b1; bus.p1_wa = 5'd0; bus.p1_wd = 32'h55;
    @(negedge clk);
    check("a0_ack",  32'(bus.p1_ack), 32'd1);
    check("a0_nowe", 32'(bus.rf_we),  32'd0);
    tick();
    bus.p1_req = 1'b0;
    @(negedge clk);
    check("a0_count", 32'(fifo_count), 32'd0);
    check("a0_nowe2", 32'(bus.rf_we),   32'd0);
    tick();

    // Reset mid-operation with 3 queued entries.
    core(1'b1, 5'd20, 32'hC0DE);
    bus.p0_req = 1'b1; bus.p0_wa = 5'd3; bus.p0_wd = 32'h33;
    tick();
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b1; bus.p1_wa = 5'd4; bus.p1_wd = 32'h44;
    tick();
    bus.p1_req = 1'b0;
    bus.p0_req = 1'b1; bus.p0_wa = 5'd5; bus.p0_wd = 32'h55;
    tick();
    bus.p0_req = 1'b0;
    @(negedge clk);
    check("mid_count3", 32'(fifo_count), 32'd3);
    tick();
    core(1'b0, 5'd0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("mid_count0", 32'(fifo_count), 32'd0);
    check("mid_kill0",  32'(kill_cnt),   32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("mid_nowe%0d", i), 32'(bus.rf_we), 32'd0);
      tick();
    end
    check("mid_count_end", 32'(fifo_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
